// File: rtl/mem_map_pkg.sv
// ---------------------------------------------------------------------------
// mem_map_pkg
// Shared definitions for the ROM/RAM memory-port arbiter:
//   ADDR_W          width of the shared 13-bit memory address
//   DEFAULT_DATA_W  default data width of the memory port
//   WAIT_W          width of the wait-state down-counter (0..15 cycles)
//   RAM_REGION_TAG  value of addr[12:11] that selects RAM (0x1800-0x1FFF)
//   arb_state_t     arbiter FSM states
//   master_id_t     identifies the fetch (m0) or data (m1) master
// ---------------------------------------------------------------------------
package mem_map_pkg;

   localparam int ADDR_W         = 13;
   localparam int DEFAULT_DATA_W = 32;
   localparam int WAIT_W         = 4;

   localparam logic [1:0] RAM_REGION_TAG = 2'b11;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } arb_state_t;

   typedef enum logic {
      MST_M0 = 1'b0,
      MST_M1 = 1'b1
   } master_id_t;

   function automatic logic addr_is_ram(input logic [ADDR_W-1:0] addr);
      return (addr[ADDR_W-1:ADDR_W-2] == RAM_REGION_TAG);
   endfunction

endpackage

// File: rtl/addr_region_dec.sv
// ---------------------------------------------------------------------------
// addr_region_dec
// Combinational region decode of a 13-bit memory address.
// Ports:
//   addr    in   13  memory address
//   is_rom  out  1   address falls in 0x0000-0x17FF
//   is_ram  out  1   address falls in 0x1800-0x1FFF
// ---------------------------------------------------------------------------
module addr_region_dec
   import mem_map_pkg::*;
(
   input  logic [ADDR_W-1:0] addr,
   output logic              is_rom,
   output logic              is_ram
);

   always_comb begin
      is_ram = addr_is_ram(addr);
      is_rom = ~is_ram;
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
// Shares the single ROM/RAM memory port between instruction fetch (m0,
// read-only) and data access (m1, read/write). Decodes the region, inserts
// per-region wait states and returns read data with a one-cycle ack.
//
// Build option: define ARB_RR_EN for round-robin arbitration between m0 and
// m1; without it m1 has fixed priority over m0.
//
// Parameters:
//   ROM_WAIT  extra access cycles for ROM (0..15)
//   RAM_WAIT  extra access cycles for RAM (0..15)
//   DATA_W    data width
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   m0_req/m0_addr           fetch request and address
//   m0_rdata/m0_ack          fetch read data and completion pulse
//   m1_req/m1_we/m1_addr     data request, write enable, address
//   m1_wdata                 data write data
//   m1_rdata/m1_ack/m1_err   data read data, completion and illegal-access pulse
//   rom_sel/ram_sel          region chip selects
//   mem_addr/mem_we          shared memory address, write enable (RAM only)
//   mem_wdata                shared memory write data
//   rom_rdata/ram_rdata      read data from the ROM/RAM macros
//
// state  | meaning
// IDLE   | waiting for a request; arbitrates and latches the winner
// ACCESS | region selected, wait counter running down to 0
// DONE   | one-cycle ack (with m1_err for a ROM write) to the granted master
// ---------------------------------------------------------------------------
module mem_bus_arbiter
   import mem_map_pkg::*;
#(
   parameter int unsigned ROM_WAIT = 2,
   parameter int unsigned RAM_WAIT = 0,
   parameter int unsigned DATA_W   = DEFAULT_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_req,
   input  logic [ADDR_W-1:0] m0_addr,
   output logic [DATA_W-1:0] m0_rdata,
   output logic              m0_ack,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              m1_ack,
   output logic              m1_err,
   output logic              rom_sel,
   output logic              ram_sel,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] rom_rdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   localparam logic [WAIT_W-1:0] ROM_WAIT_LD = WAIT_W'(ROM_WAIT);
   localparam logic [WAIT_W-1:0] RAM_WAIT_LD = WAIT_W'(RAM_WAIT);

   arb_state_t        state, state_nxt;
   master_id_t        grant;
   master_id_t        lat_master;
   logic [ADDR_W-1:0] lat_addr;
   logic              lat_we;
   logic [DATA_W-1:0] lat_wdata;
   logic              lat_err;
   logic [WAIT_W-1:0] wait_cnt;
   logic [DATA_W-1:0] m0_rdata_q;
   logic [DATA_W-1:0] m1_rdata_q;

   logic              any_req;
   logic              accept;
   logic [ADDR_W-1:0] sel_addr;
   logic              sel_we;
   logic [DATA_W-1:0] sel_wdata;
   logic              sel_is_ram;
   logic              rom_write;
   logic              lat_is_rom;
   logic              lat_is_ram;
   logic              capture;

`ifdef ARB_RR_EN
   master_id_t        rr_ptr;
`endif

   addr_region_dec u_region_dec (
      .addr   (lat_addr),
      .is_rom (lat_is_rom),
      .is_ram (lat_is_ram)
   );

   // Arbitration and selection of the winner's request fields
   always_comb begin
      any_req = m0_req | m1_req;
`ifdef ARB_RR_EN
      if (m0_req && m1_req) begin
         grant = rr_ptr;
      end else begin
         grant = m1_req ? MST_M1 : MST_M0;
      end
`else
      grant = m1_req ? MST_M1 : MST_M0;
`endif
      if (grant == MST_M1) begin
         sel_addr  = m1_addr;
         sel_we    = m1_we;
         sel_wdata = m1_wdata;
      end else begin
         sel_addr  = m0_addr;
         sel_we    = 1'b0;
         sel_wdata = lat_wdata;
      end
      // Decoded on the incoming address: the ROM-write decision and the
      // counter load must be made before the address is latched.
      sel_is_ram = addr_is_ram(sel_addr);
      rom_write  = sel_we & ~sel_is_ram;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      capture   = 1'b0;
      rom_sel   = 1'b0;
      ram_sel   = 1'b0;
      mem_we    = 1'b0;
      m0_ack    = 1'b0;
      m1_ack    = 1'b0;
      m1_err    = 1'b0;
      case (state)
         IDLE: begin
            if (any_req) begin
               accept    = 1'b1;
               state_nxt = rom_write ? DONE : ACCESS;
            end
         end
         ACCESS: begin
            rom_sel = lat_is_rom;
            ram_sel = lat_is_ram;
            mem_we  = lat_we & lat_is_ram;
            if (wait_cnt == '0) begin
               capture   = ~lat_we;
               state_nxt = DONE;
            end
         end
         DONE: begin
            m0_ack    = (lat_master == MST_M0);
            m1_ack    = (lat_master == MST_M1);
            m1_err    = (lat_master == MST_M1) & lat_err;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lat_master <= MST_M0;
         lat_addr   <= '0;
         lat_we     <= 1'b0;
         lat_wdata  <= '0;
         lat_err    <= 1'b0;
         wait_cnt   <= '0;
      end else if (accept) begin
         lat_master <= grant;
         lat_addr   <= sel_addr;
         lat_we     <= sel_we;
         lat_wdata  <= sel_wdata;
         lat_err    <= rom_write;
         wait_cnt   <= sel_is_ram ? RAM_WAIT_LD : ROM_WAIT_LD;
      end else if (state == ACCESS && wait_cnt != '0) begin
         wait_cnt <= wait_cnt - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m0_rdata_q <= '0;
         m1_rdata_q <= '0;
      end else if (capture) begin
         if (lat_master == MST_M0) begin
            m0_rdata_q <= lat_is_ram ? ram_rdata : rom_rdata;
         end else begin
            m1_rdata_q <= lat_is_ram ? ram_rdata : rom_rdata;
         end
      end
   end

`ifdef ARB_RR_EN
   // After each grant the other master gets first claim on a tie.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr <= MST_M0;
      end else if (accept) begin
         rr_ptr <= (grant == MST_M0) ? MST_M1 : MST_M0;
      end
   end
`endif

   assign m0_rdata  = m0_rdata_q;
   assign m1_rdata  = m1_rdata_q;
   assign mem_addr  = lat_addr;
   assign mem_wdata = lat_wdata;

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single 13-bit ROM/RAM memory port between instruction fetch (m0, read-only) and data access (m1, read/write).
- Arbitrates between m0 and m1, decodes the address region, and drives rom_sel/ram_sel.
- Inserts per-region wait states and returns read data with a one-cycle ack pulse.
- Sits between the core's fetch/LSU stages and the ROM/RAM macros.

Parameters:
- ROM_WAIT, 2, extra access cycles for ROM (0..15)
- RAM_WAIT, 0, extra access cycles for RAM (0..15)
- DATA_W, 32, data width

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- m0_req  in  1  fetch request
- m0_addr  in  13  fetch address
- m0_rdata  out  DATA_W  fetch read data
- m0_ack  out  1  fetch completion pulse
- m1_req  in  1  data request
- m1_we  in  1  data write enable
- m1_addr  in  13  data address
- m1_wdata  in  DATA_W  write data
- m1_rdata  out  DATA_W  data read data
- m1_ack  out  1  data completion pulse
- m1_err  out  1  illegal-access pulse, coincident with m1_ack
- rom_sel  out  1  ROM chip select
- ram_sel  out  1  RAM chip select
- mem_addr  out  13  shared memory address
- mem_we  out  1  memory write enable, RAM only
- mem_wdata  out  DATA_W  memory write data
- rom_rdata  in  DATA_W  ROM read data
- ram_rdata  in  DATA_W  RAM read data

Behaviour:
- Clocking and reset: single clock domain, rising edge of clk. rst is asynchronous, active-high.
- Reset values: all outputs 0; FSM in IDLE; round-robin pointer = m0.
- Region decode:
  - addr[12:11]==2'b11 (0x1800-0x1FFF) -> RAM.
  - All other addresses (0x0000-0x17FF) -> ROM.
  - Exactly one of rom_sel/ram_sel is high during an access; both are low otherwise.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - Samples m0_req/m1_req.
  - If any request is present: arbitrate, then latch master id, addr, we (m0: we=0), and wdata.
  - Load the wait counter with ROM_WAIT or RAM_WAIT per region.
  - Go to ACCESS.
  - Exception: m1 write to a ROM address skips ACCESS and goes straight to DONE with err set.
- ACCESS:
  - mem_addr and mem_wdata are driven from the latched values; the region select is held high; mem_we = latched we, RAM only.
  - The counter decrements each cycle.
  - When the counter reads 0, capture rom_rdata/ram_rdata into the granted master's rdata register (reads only), then go to DONE.
  - ACCESS lasts WAIT+1 cycles.
- DONE:
  - Selects and mem_we are low.
  - The granted master's ack is high for exactly one cycle; m1_err is high with it for a ROM write.
  - Next state is IDLE.
- Latency:
  - Request sampled in IDLE at cycle N -> ack at cycle N+2+WAIT.
  - Error path -> ack at cycle N+1.
- Handshake:
  - Masters hold req, addr, we and wdata stable until ack.
  - req still high in the cycle after ack is treated as a new request.
  - Requests arriving outside IDLE wait.
- rdata retention: each rdata holds its value until that master's next read completion. Writes and errors do not modify m1_rdata.
- mem_addr/mem_wdata in IDLE/DONE: hold the last latched values (don't-care to memory).
- Reset mid-transaction: the transaction is dropped, no ack is produced, and a held request is re-served from IDLE after reset release.
- Concurrent requests: never more than one outstanding transaction; ack is never asserted for both masters in the same cycle.

Optional Feature:
- Macro: ARB_RR_EN.
- Defined:
  - Round-robin arbitration. When both masters request, the pointer master wins.
  - After each grant, the pointer moves to the non-granted master.
  - A lone requester always wins.
- Undefined:
  - Fixed priority: m1 beats m0.
  - No pointer register exists.

Decomposition:
- Package mem_map_pkg:
  - ADDR_W=13, DATA_W default.
  - RAM_REGION_TAG=2'b11 for addr[12:11].
  - FSM state enum (IDLE/ACCESS/DONE).
  - Master-id type.
- Sub-module addr_region_dec: combinational 13-bit address -> is_rom/is_ram, instantiated once on the latched address.

Test Plan:
- Lone m0 ROM read (ROM_WAIT=2):
  - Stimulus: m0_req=1, m0_addr=0x0100, rom_rdata=0xDEADBEEF, sampled at cycle 0.
  - Response: rom_sel high cycles 1-3, mem_we=0; m0_ack at cycle 4 with m0_rdata=0xDEADBEEF.
- m1 RAM write (RAM_WAIT=0):
  - Stimulus: m1_we=1, m1_addr=0x1804, m1_wdata=0x12345678.
  - Response: ram_sel=mem_we=1 for one cycle (cycle 1) with mem_wdata=0x12345678; m1_ack at cycle 2; m1_err=0.
- m1 write to ROM:
  - Stimulus: m1_we=1, m1_addr=0x0804.
  - Response: no select and no mem_we; m1_ack=m1_err=1 at cycle 1; m1_rdata unchanged.
- Both masters request back-to-back, held for 4 transactions:
  - Stimulus: m0 reads 0x0000, m1 reads 0x1FFC.
  - Without ARB_RR_EN: m1 served every time, m0 starved.
  - With ARB_RR_EN: grants alternate m0, m1, m0, m1.
- Boundary addresses:
  - m0_addr=0x17FF -> rom_sel only.
  - m1 read 0x1800 -> ram_sel only, ack at N+2.
- Reset mid-access:
  - Stimulus: rst asserted in the 2nd ACCESS cycle of a ROM read.
  - Response: all outputs drop to 0 immediately, no m0_ack.
  - After release with m0_req held: full new ROM access, ack 4 cycles after the first IDLE sample.
